// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and defaults for the instruction-fetch queue
// Rev 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_XLEN    = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_mem : DEPTH-entry register array, one write port, comb. read
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 2 * FETCH_XLEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue : PC register plus a {pc, instr} FIFO between IF and ID
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               XLEN     = FETCH_XLEN,
  parameter int               DEPTH    = DEFAULT_DEPTH,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [XLEN-1:0]              pc,
  input  logic [XLEN-1:0]              instr,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [XLEN-1:0]              id_instr,
  output logic [XLEN-1:0]              id_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q,    pc_d;
  logic [AW-1:0]   rd_q,    rd_d;
  logic [AW-1:0]   wr_q,    wr_d;
  logic [CW-1:0]   count_q, count_d;

  logic   push;
  logic   pop;
  entry_t wentry;
  entry_t rentry;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign id_valid = ~empty;
  assign pop      = id_valid & id_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push     = ~redirect & (~full | pop);

  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redirect) begin
      // Flush wins over any same-cycle pop; target is halfword aligned.
      pc_d    = {redirect_pc[XLEN-1:1], 1'b0};
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + AW'(1);
        pc_d = pc_q + PC_STEP;
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign wentry = '{pc: pc_q, instr: instr};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_q),
    .wdata (wentry),
    .raddr (rd_q),
    .rdata (rentry)
  );

  assign pc       = pc_q;
  assign id_pc    = rentry.pc;
  assign id_instr = rentry.instr;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_queue : directed self-checking bench for fetch_queue (DEPTH=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] TAG = 32'hA000_0000;

  always #5 clk = ~clk;

  // Combinational instruction memory: each word encodes its own address.
  assign instr = TAG | pc;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    reset       = 1'b1;
    step();
    reset       = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    checks++; if (pc !== 32'h0)      begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (count !== 3'd0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
    checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)     begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (id_pc !== 32'h0)   begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_instr got=%h exp=0", id_instr); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (pc !== 32'(4 * k))            begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, pc, 32'(4 * k)); end
      checks++; if (id_valid !== 1'b1)            begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, id_valid); end
      checks++; if (id_pc !== 32'(4 * (k - 1)))   begin failures++; $display("FAIL stream_id_pc k=%0d got=%h exp=%h", k, id_pc, 32'(4 * (k - 1))); end
      checks++; if (id_instr !== (TAG | 32'(4 * (k - 1)))) begin failures++; $display("FAIL stream_id_instr k=%0d got=%h exp=%h", k, id_instr, TAG | 32'(4 * (k - 1))); end
      checks++; if (count !== 3'd1)               begin failures++; $display("FAIL stream_count k=%0d got=%0d exp=1", k, count); end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  exp_cnt;
    logic [31:0] exp_pc;
    do_reset();
    id_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_cnt = (k > 4) ? 3'd4 : 3'(k);
      exp_pc  = (k > 4) ? 32'h10 : 32'(4 * k);
      checks++; if (count !== exp_cnt)           begin failures++; $display("FAIL bp_count k=%0d got=%0d exp=%0d", k, count, exp_cnt); end
      checks++; if (full !== (exp_cnt == 3'd4))  begin failures++; $display("FAIL bp_full k=%0d got=%b exp=%b", k, full, exp_cnt == 3'd4); end
      checks++; if (pc !== exp_pc)               begin failures++; $display("FAIL bp_pc k=%0d got=%h exp=%h", k, pc, exp_pc); end
      checks++; if (id_pc !== 32'h0)             begin failures++; $display("FAIL bp_head_stable k=%0d got=%h exp=0", k, id_pc); end
      checks++; if (empty !== 1'b0)              begin failures++; $display("FAIL bp_empty k=%0d got=%b exp=0", k, empty); end
    end
  endtask

  // Continues from a full queue: pops with a simultaneous write into the freed slot.
  task automatic test_full_pop();
    logic [31:0] exp_id [5];
    logic [31:0] exp_pc [5];
    logic        rdy    [5];
    exp_id = '{32'h4, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_pc = '{32'h14, 32'h14, 32'h18, 32'h1C, 32'h20};
    rdy    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      id_ready = rdy[k];
      step();
      checks++; if (count !== 3'd4)     begin failures++; $display("FAIL fullpop_count k=%0d got=%0d exp=4", k, count); end
      checks++; if (pc !== exp_pc[k])   begin failures++; $display("FAIL fullpop_pc k=%0d got=%h exp=%h", k, pc, exp_pc[k]); end
      checks++; if (id_pc !== exp_id[k]) begin failures++; $display("FAIL fullpop_id_pc k=%0d got=%h exp=%h", k, id_pc, exp_id[k]); end
      checks++; if (id_instr !== (TAG | exp_id[k])) begin failures++; $display("FAIL fullpop_id_instr k=%0d got=%h exp=%h", k, id_instr, TAG | exp_id[k]); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    id_ready = 1'b0;
    repeat (3) step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
    redirect    = 1'b1;
    redirect_pc = 32'h101;
    step();
    redirect = 1'b0;
    checks++; if (count !== 3'd0)     begin failures++; $display("FAIL redir_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0)  begin failures++; $display("FAIL redir_valid got=%b exp=0", id_valid); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL redir_empty got=%b exp=1", empty); end
    checks++; if (pc !== 32'h100)     begin failures++; $display("FAIL redir_pc got=%h exp=100", pc); end
    step();
    checks++; if (id_valid !== 1'b1)  begin failures++; $display("FAIL redir_next_valid got=%b exp=1", id_valid); end
    checks++; if (id_pc !== 32'h100)  begin failures++; $display("FAIL redir_next_id_pc got=%h exp=100", id_pc); end
    checks++; if (id_instr !== 32'hA000_0100) begin failures++; $display("FAIL redir_next_id_instr got=%h exp=a0000100", id_instr); end
    checks++; if (count !== 3'd1)     begin failures++; $display("FAIL redir_next_count got=%0d exp=1", count); end
    checks++; if (pc !== 32'h104)     begin failures++; $display("FAIL redir_next_pc got=%h exp=104", pc); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    id_ready = 1'b0;
    repeat (2) step();
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL rpop_pre_count got=%0d exp=2", count); end
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    id_ready    = 1'b1;
    step();
    redirect = 1'b0;
    id_ready = 1'b0;
    checks++; if (count !== 3'd0)    begin failures++; $display("FAIL rpop_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rpop_valid got=%b exp=0", id_valid); end
    checks++; if (pc !== 32'h200)    begin failures++; $display("FAIL rpop_pc got=%h exp=200", pc); end
    step();
    checks++; if (count !== 3'd1)    begin failures++; $display("FAIL rpop_next_count got=%0d exp=1", count); end
    checks++; if (id_pc !== 32'h200) begin failures++; $display("FAIL rpop_next_id_pc got=%h exp=200", id_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    id_ready = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    checks++; if (pc !== 32'h300)  begin failures++; $display("FAIL b2b_first_pc got=%h exp=300", pc); end
    checks++; if (count !== 3'd0)  begin failures++; $display("FAIL b2b_first_count got=%0d exp=0", count); end
    redirect_pc = 32'h401;
    step();
    redirect = 1'b0;
    checks++; if (pc !== 32'h400)  begin failures++; $display("FAIL b2b_second_pc got=%h exp=400", pc); end
    checks++; if (count !== 3'd0)  begin failures++; $display("FAIL b2b_second_count got=%0d exp=0", count); end
    step();
    checks++; if (id_pc !== 32'h400) begin failures++; $display("FAIL b2b_id_pc got=%h exp=400", id_pc); end
    checks++; if (count !== 3'd1)    begin failures++; $display("FAIL b2b_count got=%0d exp=1", count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'h34;
    step();
    redirect = 1'b0;
    id_ready = 1'b0;
    repeat (3) step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
    checks++; if (pc !== 32'h40)  begin failures++; $display("FAIL areset_pre_pc got=%h exp=40", pc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (pc !== 32'h0)      begin failures++; $display("FAIL areset_pc got=%h exp=0", pc); end
    checks++; if (count !== 3'd0)    begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", id_valid); end
    checks++; if (id_pc !== 32'h0)   begin failures++; $display("FAIL areset_id_pc got=%h exp=0", id_pc); end
    reset    = 1'b0;
    id_ready = 1'b1;
    step();
    checks++; if (count !== 3'd1)    begin failures++; $display("FAIL areset_refill_count got=%0d exp=1", count); end
    checks++; if (id_pc !== 32'h0)   begin failures++; $display("FAIL areset_refill_id_pc got=%h exp=0", id_pc); end
    checks++; if (pc !== 32'h4)      begin failures++; $display("FAIL areset_refill_pc got=%h exp=4", pc); end
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
